// File: rtl/solve_sequencer_pkg.sv
// Shared definitions for the solve sequencer: FSM state encoding,
// default coordinate width, and solve-time counter width/saturation value.
package solve_sequencer_pkg;

    localparam int COORD_W_DEF = 27;
    localparam int TIME_W      = 32;
    localparam logic [TIME_W-1:0] TIME_SAT = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LATCH   = 3'd1,
        ST_RST     = 3'd2,
        ST_SOLVE   = 3'd3,
        ST_DISPLAY = 3'd4
    } state_t;

endpackage

// File: rtl/solve_sequencer_edge_detect.sv
// Rising-edge detector: registers the input history and flags a cycle in
// which the input is high while its previous sample was low. The pulse is
// available in the same cycle as the edge so that a request arriving
// together with frame_end can still be acted on in that cycle.
module edge_detect (
    input  logic clock,
    input  logic reset,
    input  logic i_sig,
    output logic o_rise
);

    logic r_prev;

    // Sample the input history once per cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= i_sig;
        end
    end

    assign o_rise = i_sig & ~r_prev;

endmodule

// File: rtl/solve_sequencer.sv
// Solve sequencer: latches HPS view parameters, pulses the multi-solver
// reset, times the solve, then enables pixel streaming until a new request
// can be taken at a packet boundary.
// Optional feature: define PARAM_WATCH_EN to raise a request automatically
// whenever an HPS view parameter differs from its shadow while displaying.
module solve_sequencer
    import solve_sequencer_pkg::*;
#(
    parameter int COORD_W      = COORD_W_DEF,
    parameter int RESET_CYCLES = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic signed [COORD_W-1:0] min_x_in,
    input  logic signed [COORD_W-1:0] min_y_in,
    input  logic signed [COORD_W-1:0] dx_in,
    input  logic signed [COORD_W-1:0] dy_in,
    input  logic                      frame_end,
    input  logic                      solver_done,
    output logic                      solver_reset,
    output logic signed [COORD_W-1:0] min_x,
    output logic signed [COORD_W-1:0] min_y,
    output logic signed [COORD_W-1:0] dx,
    output logic signed [COORD_W-1:0] dy,
    output logic                      stream_en,
    output logic [TIME_W-1:0]         solve_time,
    output logic                      busy,
    output logic                      done
);

    localparam logic [7:0] RST_LAST = 8'(RESET_CYCLES - 1);

    state_t r_state;
    state_t w_next;

    logic                      w_start_rise;
    logic                      w_param_diff;
    logic                      w_pending_eff;
    logic                      r_pending;
    logic [7:0]                r_rst_cnt;
    logic [TIME_W-1:0]         r_count;
    logic [TIME_W-1:0]         r_solve_time;
    logic signed [COORD_W-1:0] r_min_x;
    logic signed [COORD_W-1:0] r_min_y;
    logic signed [COORD_W-1:0] r_dx;
    logic signed [COORD_W-1:0] r_dy;
    logic                      r_solver_reset;
    logic                      r_stream_en;
    logic                      r_busy;
    logic                      r_done;

    edge_detect u_start_edge (
        .clock  (clock),
        .reset  (reset),
        .i_sig  (start),
        .o_rise (w_start_rise)
    );

`ifdef PARAM_WATCH_EN
    // Parameter change while displaying counts as a new request.
    always_comb begin
        w_param_diff = 1'b0;
        if (r_state == ST_DISPLAY) begin
            w_param_diff = (min_x_in != r_min_x) || (min_y_in != r_min_y) ||
                           (dx_in != r_dx) || (dy_in != r_dy);
        end else begin
            w_param_diff = 1'b0;
        end
    end
`else
    assign w_param_diff = 1'b0;
`endif

    // A request seen this cycle is usable immediately, not only next cycle.
    assign w_pending_eff = r_pending | w_start_rise | w_param_diff;

    // Next-state decision; solver_done only matters in SOLVE, and DISPLAY
    // only leaves on a packet boundary so a frame is never cut short.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_pending_eff) w_next = ST_LATCH;
                else               w_next = ST_IDLE;
            end
            ST_LATCH: begin
                w_next = ST_RST;
            end
            ST_RST: begin
                if (r_rst_cnt == RST_LAST) w_next = ST_SOLVE;
                else                       w_next = ST_RST;
            end
            ST_SOLVE: begin
                if (solver_done) w_next = w_pending_eff ? ST_LATCH : ST_DISPLAY;
                else             w_next = ST_SOLVE;
            end
            ST_DISPLAY: begin
                if (frame_end && w_pending_eff) w_next = ST_LATCH;
                else                            w_next = ST_DISPLAY;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // State register with outputs decoded from the next state so they are registered.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_solver_reset <= 1'b1;
            r_stream_en    <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_state        <= w_next;
            r_solver_reset <= (w_next == ST_IDLE) || (w_next == ST_RST);
            r_stream_en    <= (w_next == ST_DISPLAY);
            r_busy         <= (w_next == ST_LATCH) || (w_next == ST_RST) ||
                              (w_next == ST_SOLVE);
            r_done         <= (w_next == ST_DISPLAY);
        end
    end

    // Pending request flag: set by any request, consumed on LATCH entry.
    // Comes out of reset set so the first frame is solved without a request.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pending <= 1'b1;
        end else if (w_next == ST_LATCH) begin
            r_pending <= 1'b0;
        end else begin
            r_pending <= w_pending_eff;
        end
    end

    // Length of the solver reset pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rst_cnt <= 8'd0;
        end else if (r_state == ST_RST) begin
            r_rst_cnt <= r_rst_cnt + 8'd1;
        end else begin
            r_rst_cnt <= 8'd0;
        end
    end

    // Solve cycle counter: cleared while the solver is held in reset,
    // counts during SOLVE and sticks at the saturation value.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (r_state == ST_RST) begin
            r_count <= '0;
        end else if ((r_state == ST_SOLVE) && (r_count != TIME_SAT)) begin
            r_count <= r_count + 32'd1;
        end else begin
            r_count <= r_count;
        end
    end

    // Capture the solve time when the solver reports completion.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_solve_time <= '0;
        end else if ((r_state == ST_SOLVE) && solver_done) begin
            r_solve_time <= r_count;
        end else begin
            r_solve_time <= r_solve_time;
        end
    end

    // Shadow the view parameters only in LATCH so the solver sees a stable set.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_min_x <= '0;
            r_min_y <= '0;
            r_dx    <= '0;
            r_dy    <= '0;
        end else if (r_state == ST_LATCH) begin
            r_min_x <= min_x_in;
            r_min_y <= min_y_in;
            r_dx    <= dx_in;
            r_dy    <= dy_in;
        end else begin
            r_min_x <= r_min_x;
            r_min_y <= r_min_y;
            r_dx    <= r_dx;
            r_dy    <= r_dy;
        end
    end

    assign solver_reset = r_solver_reset;
    assign stream_en    = r_stream_en;
    assign busy         = r_busy;
    assign done         = r_done;
    assign solve_time   = r_solve_time;
    assign min_x        = r_min_x;
    assign min_y        = r_min_y;
    assign dx           = r_dx;
    assign dy           = r_dy;

endmodule

// File: tb/tb_solve_sequencer.sv
// Self-checking bench for solve_sequencer with scoreboard queues for the
// latched parameter sets and the expected solve times.
// Honours PARAM_WATCH_EN the same way as the design.
module tb_solve_sequencer;

    localparam int CW = 27;

    typedef struct packed {
        logic [CW-1:0] mx;
        logic [CW-1:0] my;
        logic [CW-1:0] dx;
        logic [CW-1:0] dy;
    } shadow_t;

    logic                 clock = 1'b0;
    logic                 reset = 1'b1;
    logic                 start = 1'b0;
    logic                 frame_end = 1'b0;
    logic                 solver_done = 1'b0;
    logic signed [CW-1:0] min_x_in = '0;
    logic signed [CW-1:0] min_y_in = '0;
    logic signed [CW-1:0] dx_in = '0;
    logic signed [CW-1:0] dy_in = '0;
    logic                 solver_reset;
    logic signed [CW-1:0] min_x;
    logic signed [CW-1:0] min_y;
    logic signed [CW-1:0] dx;
    logic signed [CW-1:0] dy;
    logic                 stream_en;
    logic [31:0]          solve_time;
    logic                 busy;
    logic                 done;

    int n_vec = 0;
    int n_err = 0;

    shadow_t     sh_q[$];
    logic [31:0] time_q[$];

    solve_sequencer dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .min_x_in     (min_x_in),
        .min_y_in     (min_y_in),
        .dx_in        (dx_in),
        .dy_in        (dy_in),
        .frame_end    (frame_end),
        .solver_done  (solver_done),
        .solver_reset (solver_reset),
        .min_x        (min_x),
        .min_y        (min_y),
        .dx           (dx),
        .dy           (dy),
        .stream_en    (stream_en),
        .solve_time   (solve_time),
        .busy         (busy),
        .done         (done)
    );

    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drive new view parameters and record the set the next LATCH must capture.
    task automatic set_params(input logic [CW-1:0] a, input logic [CW-1:0] b,
                              input logic [CW-1:0] c, input logic [CW-1:0] d);
        shadow_t s;
        min_x_in = a;
        min_y_in = b;
        dx_in    = c;
        dy_in    = d;
        s = {a, b, c, d};
        sh_q.push_back(s);
    endtask

    // From a LATCH cycle, wait through RST; ends on the first SOLVE cycle.
    task automatic run_to_solve(output int rst_len, output bit ok);
        int guard;
        guard   = 0;
        rst_len = 0;
        @(negedge clock);
        while (!(solver_reset === 1'b1 && busy === 1'b1) && guard < 50) begin
            @(negedge clock);
            guard++;
        end
        while (solver_reset === 1'b1 && guard < 400) begin
            rst_len++;
            @(negedge clock);
            guard++;
        end
        ok = (guard < 400) && (busy === 1'b1) && (solver_reset === 1'b0);
    endtask

    task automatic test_reset();
        int len; bit ok; shadow_t e;
        reset = 1'b1;
        set_params(27'h0123456, 27'h7FFFF00, 27'h0000100, 27'h0000200);
        repeat (2) @(negedge clock);
        n_vec++;
        if ({solver_reset, busy, done, stream_en} !== 4'b1000) begin
            n_err++; $display("FAIL reset_ctrl got %b exp 1000", {solver_reset, busy, done, stream_en});
        end
        n_vec++;
        if (solve_time !== 32'd0) begin
            n_err++; $display("FAIL reset_time got %0d exp 0", solve_time);
        end
        n_vec++;
        if ({min_x, min_y, dx, dy} !== {4*CW{1'b0}}) begin
            n_err++; $display("FAIL reset_shadow got %h exp 0", {min_x, min_y, dx, dy});
        end
        reset = 1'b0;
        @(negedge clock);
        n_vec++;
        if ({solver_reset, busy, done, stream_en} !== 4'b0100) begin
            n_err++; $display("FAIL first_latch got %b exp 0100", {solver_reset, busy, done, stream_en});
        end
        run_to_solve(len, ok);
        n_vec++;
        if (!ok || len != 4) begin
            n_err++; $display("FAIL first_rst_len got %0d ok=%0d exp 4", len, ok);
        end
        e = sh_q.pop_front();
        n_vec++;
        if ({min_x, min_y, dx, dy} !== e) begin
            n_err++; $display("FAIL first_shadow got %h exp %h", {min_x, min_y, dx, dy}, e);
        end
    endtask

    task automatic test_solve_time();
        logic [31:0] e;
        repeat (100) @(negedge clock);
        solver_done = 1'b1;
        time_q.push_back(32'd100);
        @(negedge clock);
        solver_done = 1'b0;
        e = time_q.pop_front();
        n_vec++;
        if (solve_time !== e) begin
            n_err++; $display("FAIL solve_time_100 got %0d exp %0d", solve_time, e);
        end
        n_vec++;
        if ({solver_reset, busy, done, stream_en} !== 4'b0011) begin
            n_err++; $display("FAIL display_entry got %b exp 0011", {solver_reset, busy, done, stream_en});
        end
    endtask

    task automatic test_display_hold();
        int bad; int len; bit ok; shadow_t e; logic [31:0] t;
        bad = 0;
        set_params(27'h0000ABC, 27'h0000DEF, 27'h7FFFFFF, 27'h0000001);
        start = 1'b1;
        for (int i = 0; i < 499; i++) begin
            @(negedge clock);
            start = 1'b0;
            if (stream_en !== 1'b1 || busy !== 1'b0) bad++;
        end
        @(negedge clock);
        frame_end = 1'b1;
        if (stream_en !== 1'b1) bad++;
        n_vec++;
        if (bad != 0) begin
            n_err++; $display("FAIL display_hold bad_cycles got %0d exp 0", bad);
        end
        @(negedge clock);
        frame_end = 1'b0;
        n_vec++;
        if ({solver_reset, busy, done, stream_en} !== 4'b0100) begin
            n_err++; $display("FAIL latch_at_frame_end got %b exp 0100", {solver_reset, busy, done, stream_en});
        end
        run_to_solve(len, ok);
        n_vec++;
        if (!ok || len != 4) begin
            n_err++; $display("FAIL hold_rst_len got %0d ok=%0d exp 4", len, ok);
        end
        e = sh_q.pop_front();
        n_vec++;
        if ({min_x, min_y, dx, dy} !== e) begin
            n_err++; $display("FAIL hold_shadow got %h exp %h", {min_x, min_y, dx, dy}, e);
        end
        repeat (37) @(negedge clock);
        solver_done = 1'b1;
        time_q.push_back(32'd37);
        @(negedge clock);
        solver_done = 1'b0;
        t = time_q.pop_front();
        n_vec++;
        if (solve_time !== t || done !== 1'b1) begin
            n_err++; $display("FAIL hold_time got %0d done=%b exp %0d done=1", solve_time, done, t);
        end
    endtask

    task automatic test_back_to_back();
        int len; bit ok; int bad; shadow_t e; logic [31:0] t;
        // start edge coinciding with frame_end
        set_params(27'h0001000, 27'h0002000, 27'h0000010, 27'h0000020);
        start = 1'b1;
        frame_end = 1'b1;
        @(negedge clock);
        start = 1'b0;
        frame_end = 1'b0;
        n_vec++;
        if ({solver_reset, busy, done, stream_en} !== 4'b0100) begin
            n_err++; $display("FAIL edge_with_frame_end got %b exp 0100", {solver_reset, busy, done, stream_en});
        end
        run_to_solve(len, ok);
        e = sh_q.pop_front();
        n_vec++;
        if (!ok || {min_x, min_y, dx, dy} !== e) begin
            n_err++; $display("FAIL b2b_shadow1 got %h ok=%0d exp %h", {min_x, min_y, dx, dy}, ok, e);
        end
        set_params(27'h7000000, 27'h0FFFFFF, 27'h0000033, 27'h0000044);
        for (int i = 1; i <= 20; i++) begin
            @(negedge clock);
            start = (i <= 6) && (i % 2 == 1);
        end
        solver_done = 1'b1;
        time_q.push_back(32'd20);
        @(negedge clock);
        solver_done = 1'b0;
        t = time_q.pop_front();
        n_vec++;
        if (solve_time !== t) begin
            n_err++; $display("FAIL b2b_time got %0d exp %0d", solve_time, t);
        end
        n_vec++;
        if ({solver_reset, busy, done, stream_en} !== 4'b0100) begin
            n_err++; $display("FAIL b2b_relatch got %b exp 0100", {solver_reset, busy, done, stream_en});
        end
        run_to_solve(len, ok);
        e = sh_q.pop_front();
        n_vec++;
        if (!ok || len != 4 || {min_x, min_y, dx, dy} !== e) begin
            n_err++; $display("FAIL b2b_shadow2 got %h len=%0d exp %h len=4", {min_x, min_y, dx, dy}, len, e);
        end
        repeat (5) @(negedge clock);
        solver_done = 1'b1;
        @(negedge clock);
        solver_done = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (solver_reset !== 1'b0 || busy !== 1'b0 || done !== 1'b1) bad++;
            @(negedge clock);
        end
        n_vec++;
        if (bad != 0) begin
            n_err++; $display("FAIL b2b_single_extra bad_cycles got %0d exp 0", bad);
        end
    endtask

    task automatic test_mid_reset();
        int len; bit ok; shadow_t e; logic [31:0] t;
        set_params(27'h0000555, 27'h0000666, 27'h0000777, 27'h0000888);
        start = 1'b1;
        frame_end = 1'b1;
        @(negedge clock);
        start = 1'b0;
        frame_end = 1'b0;
        run_to_solve(len, ok);
        e = sh_q.pop_front();
        n_vec++;
        if (!ok || {min_x, min_y, dx, dy} !== e) begin
            n_err++; $display("FAIL pre_reset_shadow got %h ok=%0d exp %h", {min_x, min_y, dx, dy}, ok, e);
        end
        repeat (50) @(negedge clock);
        reset = 1'b1;
        #1;
        n_vec++;
        if ({solver_reset, busy, done, stream_en} !== 4'b1000 || solve_time !== 32'd0 ||
            {min_x, min_y, dx, dy} !== {4*CW{1'b0}}) begin
            n_err++; $display("FAIL async_reset got ctrl=%b time=%0d sh=%h exp ctrl=1000 time=0 sh=0",
                              {solver_reset, busy, done, stream_en}, solve_time, {min_x, min_y, dx, dy});
        end
        @(negedge clock);
        set_params(27'h0000555, 27'h0000666, 27'h0000777, 27'h0000888);
        reset = 1'b0;
        @(negedge clock);
        n_vec++;
        if ({solver_reset, busy, done, stream_en} !== 4'b0100) begin
            n_err++; $display("FAIL relatch_after_reset got %b exp 0100", {solver_reset, busy, done, stream_en});
        end
        run_to_solve(len, ok);
        e = sh_q.pop_front();
        n_vec++;
        if (!ok || len != 4 || {min_x, min_y, dx, dy} !== e) begin
            n_err++; $display("FAIL post_reset_solve got %h len=%0d exp %h len=4", {min_x, min_y, dx, dy}, len, e);
        end
        repeat (7) @(negedge clock);
        solver_done = 1'b1;
        time_q.push_back(32'd7);
        @(negedge clock);
        solver_done = 1'b0;
        t = time_q.pop_front();
        n_vec++;
        if (solve_time !== t || done !== 1'b1) begin
            n_err++; $display("FAIL post_reset_time got %0d done=%b exp %0d done=1", solve_time, done, t);
        end
    endtask

    task automatic test_watch();
        int bad; shadow_t keep;
`ifdef PARAM_WATCH_EN
        int len; bit ok; shadow_t e;
`endif
        keep = {min_x, min_y, dx, dy};
        bad = 0;
        solver_done = 1'b1;
        repeat (3) begin
            @(negedge clock);
            if (done !== 1'b1 || busy !== 1'b0 || solve_time !== 32'd7) bad++;
        end
        solver_done = 1'b0;
        n_vec++;
        if (bad != 0) begin
            n_err++; $display("FAIL done_ignored_in_display bad_cycles got %0d exp 0", bad);
        end
        dx_in = dx_in + 27'sd1;
`ifdef PARAM_WATCH_EN
        sh_q.push_back({min_x_in, min_y_in, dx_in, dy_in});
`endif
        bad = 0;
        repeat (10) begin
            @(negedge clock);
            if (done !== 1'b1 || stream_en !== 1'b1) bad++;
        end
        n_vec++;
        if (bad != 0) begin
            n_err++; $display("FAIL watch_waits_frame_end bad_cycles got %0d exp 0", bad);
        end
        frame_end = 1'b1;
        @(negedge clock);
        frame_end = 1'b0;
`ifdef PARAM_WATCH_EN
        n_vec++;
        if ({solver_reset, busy, done, stream_en} !== 4'b0100) begin
            n_err++; $display("FAIL watch_latch got %b exp 0100", {solver_reset, busy, done, stream_en});
        end
        run_to_solve(len, ok);
        e = sh_q.pop_front();
        n_vec++;
        if (!ok || {min_x, min_y, dx, dy} !== e) begin
            n_err++; $display("FAIL watch_shadow got %h ok=%0d exp %h", {min_x, min_y, dx, dy}, ok, e);
        end
`else
        n_vec++;
        if ({solver_reset, busy, done, stream_en} !== 4'b0011 || {min_x, min_y, dx, dy} !== keep) begin
            n_err++; $display("FAIL no_watch_stays got ctrl=%b sh=%h exp ctrl=0011 sh=%h",
                              {solver_reset, busy, done, stream_en}, {min_x, min_y, dx, dy}, keep);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_solve_time();
        test_display_hold();
        test_back_to_back();
        test_mid_reset();
        test_watch();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/solve_sequencer.md
SOLVE_SEQUENCER -- requirements
Module: solve_sequencer

Interface
REQ-001 SHALL have parameter COORD_W, default 27, width of signed fixed-point coordinate words.
REQ-002 SHALL have parameter RESET_CYCLES, default 4, solver reset pulse length in cycles (legal range 1-255).
REQ-003 SHALL have port clock  in  1  system clock; all logic on rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  in  1  HPS solve request; each rising edge is one request.
REQ-006 SHALL have ports min_x_in, min_y_in, dx_in, dy_in  in  COORD_W signed  HPS view parameters.
REQ-007 SHALL have port frame_end  in  1  single-cycle pulse at the last accepted beat of a video packet (end & valid & ready).
REQ-008 SHALL have port solver_done  in  1  multi-solver completion level.
REQ-009 SHALL have port solver_reset  out  1  reset to multi-solver.
REQ-010 SHALL have ports min_x, min_y, dx, dy  out  COORD_W signed  shadowed parameters to the solver.
REQ-011 SHALL have port stream_en  out  1  enable for the pixel iterator.
REQ-012 SHALL have port solve_time  out  32  cycle count of the last completed solve.
REQ-013 SHALL have ports busy  out  1 (state is LATCH, RST or SOLVE) and done  out  1 (state is DISPLAY).

Function
REQ-014 SHALL implement states IDLE, LATCH, RST, SOLVE, DISPLAY.
REQ-015 SHALL register start each cycle; a rising edge (start=1, previous=0) SHALL set flag pending.
REQ-016 IDLE SHALL go to LATCH when pending=1; pending SHALL clear on LATCH entry.
REQ-017 LATCH SHALL last exactly 1 cycle, copy the four *_in inputs into the shadows, then go to RST.
REQ-018 RST SHALL hold solver_reset=1 for exactly RESET_CYCLES cycles, clear the cycle counter to 0, then go to SOLVE.
REQ-019 solver_done SHALL be ignored in all states except SOLVE.
REQ-020 SOLVE SHALL increment the counter every cycle, saturating at 0xFFFFFFFF.
REQ-021 When solver_done=1 is sampled in SOLVE, solve_time SHALL load the current counter value.
REQ-022 On that same solver_done, the next state SHALL be LATCH if pending=1, else DISPLAY.
REQ-023 DISPLAY SHALL drive stream_en=1; stream_en SHALL be 0 in every other state.
REQ-024 DISPLAY with pending=1 SHALL go to LATCH only in the cycle frame_end=1, so packets are never truncated.
REQ-025 A start edge coinciding with frame_end in DISPLAY SHALL cause the LATCH transition in that cycle.
REQ-026 A start edge arriving in LATCH, RST or SOLVE SHALL set pending; multiple edges SHALL collapse to one request.
REQ-027 solve_time SHALL hold its value until the next solver_done in SOLVE.
REQ-028 Shadow outputs SHALL change only in LATCH.

Reset
REQ-029 SHALL force, asynchronously at any time including mid-solve, the following values:
- state IDLE, pending=1 (first frame solves automatically), start history 0;
- shadows 0, counter 0, solve_time 0;
- solver_reset=1, stream_en=0, busy=0, done=0.
REQ-030 solver_reset SHALL be 1 in IDLE and RST, 0 in LATCH, SOLVE and DISPLAY.

Configuration
REQ-031 With PARAM_WATCH_EN defined, SHALL set pending in DISPLAY whenever any *_in value differs from its shadow.
REQ-032 Without PARAM_WATCH_EN, only start edges SHALL set pending; no comparators SHALL be synthesized.

Structure
REQ-033 Shared package SHALL hold:
- the state enum;
- COORD_W default;
- the 32-bit time width;
- the saturation constant 0xFFFFFFFF.
REQ-034 SHALL contain one sub-module, edge_detect (registered rising-edge pulse); all other logic SHALL be inline.

Verification
REQ-035 Release reset with start=0 -> LATCH next cycle, solver_reset high exactly 4 cycles, shadows equal inputs.
REQ-036 solver_done asserted 100 cycles after SOLVE entry -> solve_time=100, done=1, stream_en=1.
REQ-037 In DISPLAY, start edge, frame_end 500 cycles later -> stream_en stays 1 until the frame_end cycle, LATCH the next cycle.
REQ-038 Three start edges during SOLVE -> exactly one extra LATCH/RST/SOLVE sequence, DISPLAY not entered in between.
REQ-039 Reset asserted mid-SOLVE with counter=50 -> all outputs at reset values immediately; new solve starts after release.
REQ-040 Under PARAM_WATCH_EN, dx_in changed in DISPLAY -> LATCH at next frame_end; without the macro -> stays in DISPLAY.
